result_drain: RTL and testbench
===============================

# result_drain

Downstream stage of the 32-channel result buffer. Captures each complete 32-word frame on the buffer's one-cycle `srdyo` pulse into one of two ping-pong banks, then streams the words out one per accepted handshake, in channel order 0..31, tagged with channel index and a last flag. Double buffering lets the next frame arrive while the current frame drains. Frames that arrive with both banks occupied are dropped, flagged and counted.

## Interface
- `NCH`, 32: channels per frame; must be a power of two.
- `W`, 21: result word width.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: one clock; reset is asynchronous and active-high.
- `srdyi`  in  1: frame-valid pulse from the result buffer; one cycle wide.
- `res_0` … `res_31`  in  W each: frame words, valid in the `srdyi` cycle.
- `drdyi`  in  1: consumer ready.
- `ovf_clr`  in  1: synchronous clear of `ovf` and `drop_cnt`.
- `srdyo`  out  1: output word valid.
- `dout`  out  W: current word; 0 when `srdyo`=0.
- `ch`  out  5: channel index of `dout`.
- `last`  out  1: `srdyo` && `ch`==NCH-1.
- `ovf`  out  1: sticky flag; set when a frame is dropped.
- `drop_cnt`  out  8: dropped-frame count; saturates at 255.

## Operation
- State: two banks (NCH×W), `full[1:0]`, `wr_bank`, `rd_bank`, read FSM {IDLE, STREAM}, index `idx` (5 b).
- Capture: when `srdyi`=1 and bank `wr_bank` is free, load all NCH inputs into that bank, set `full[wr_bank]` and toggle `wr_bank`.
- Drop: if `srdyi`=1 and bank `wr_bank` is full and not being released this cycle, discard the frame. Set `ovf`, increment `drop_cnt` (saturating), and leave banks and pointers unchanged.
- IDLE: if `full[rd_bank]`, go to STREAM with `idx`=0. Otherwise stay in IDLE.
- STREAM: `srdyo`=1, `dout`=bank[`rd_bank`][`idx`], `ch`=`idx`.
  - On `srdyo`&&`drdyi` with `idx`<NCH-1: `idx`++.
  - On `srdyo`&&`drdyi` with `idx`=NCH-1: clear `full[rd_bank]`, toggle `rd_bank`, set `idx`=0.
    - If the other bank is full, stay in STREAM with no bubble.
    - Otherwise go to IDLE.
- Handshake rule: while `srdyo`=1 and `drdyi`=0, `dout`, `ch` and `last` hold stable. `srdyo` never drops without a transfer.
- Simultaneous capture and release of the same bank, which happens when both banks are full (`wr_bank`==`rd_bank`): the capture is accepted and the bank stays full with the new data. It is not counted as a drop.
- `ovf_clr` and a drop in the same cycle: the drop wins (`ovf`=1, `drop_cnt`=1).
- All outputs are functions of registers only. There is no combinational path from `srdyi`, `res_*` or `drdyi` to any output.

## Timing
- Reset values:
  - `srdyo`=0, `dout`=0, `ch`=0, `last`=0, `ovf`=0, `drop_cnt`=0.
  - FSM=IDLE, `full`=0, `wr_bank`=`rd_bank`=0, `idx`=0.
  - Bank contents are not reset.
- Latency: `srdyi` sampled at edge k gives `srdyo`=1 with `ch`=0 after edge k+1.
- Throughput: with `drdyi` held at 1, one word per cycle, so a frame drains in NCH cycles. Back-to-back frames drain in 2×NCH cycles with no gap.
- Reset asserted mid-stream: all queued frames are discarded. Outputs take their reset values asynchronously.

## Structure
- Package `result_pkg` holds:
  - `RES_W`=21 and `RES_NCH`=32;
  - the FSM enum `drain_state_t` {IDLE, STREAM};
  - the `W`-wide result word typedef.
- Sub-module `result_bank`: one NCH×W register array with a parallel-load enable and a `idx`-addressed read mux. It is instantiated twice.
- The top level holds the pointers, `full` bits, FSM, drop counter and output gating.

## Test plan
- Single frame, `res_i`=i+100, `drdyi`=1 → `srdyo` high 2 cycles after `srdyi` for exactly 32 cycles. `dout`=100..131, `ch`=0..31, `last` only on `ch`=31, then IDLE.
- Backpressure: `drdyi` toggles 1,0,0,1… → each word is held stable while stalled. All 32 words arrive in order with no duplicates or losses.
- Two frames 1 cycle apart, `drdyi`=1 → 64 consecutive valid cycles with no bubble. The second frame's data follows `ch`=31 of the first.
- Three frames while `drdyi`=0 → third frame dropped: `ovf`=1, `drop_cnt`=1. The first two frames drain intact. `ovf_clr` then gives `ovf`=0, `drop_cnt`=0.
- Both banks full, and `srdyi` coincides with the final handshake of the current bank → the new frame is accepted (not dropped) and streamed after the other bank.
- Reset asserted at `ch`=10 of a frame → outputs are 0 immediately. No stale words appear after reset release, and the next frame streams from `ch`=0.

Source files
------------

// File: rtl/result_pkg.sv
// Shared types and sizes for the result-buffer drain stage.
package result_pkg;

  localparam int unsigned RES_W     = 21;
  localparam int unsigned RES_NCH   = 32;
  localparam int unsigned RES_IDX_W = $clog2(RES_NCH);

  typedef logic [RES_W-1:0] res_word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

endpackage

// File: rtl/result_bank.sv
// One frame of result words: parallel load of all channels, indexed read.
module result_bank
  import result_pkg::*;
#(
  parameter int unsigned NCH = RES_NCH,
  parameter int unsigned W   = RES_W,
  localparam int unsigned IW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          i_load,
  input  logic [W-1:0]  i_data [NCH],
  input  logic [IW-1:0] i_idx,
  output logic [W-1:0]  o_word
);

  logic [W-1:0] r_mem [NCH];

  // Contents are intentionally not reset; the full bits qualify them.
  always_ff @(posedge clk) begin
    if (i_load) r_mem <= i_data;
  end

  assign o_word = r_mem[i_idx];

endmodule

// File: rtl/result_drain.sv
// Ping-pong capture of 32-word result frames and in-order word streaming.
module result_drain
  import result_pkg::*;
#(
  parameter int unsigned NCH = RES_NCH,
  parameter int unsigned W   = RES_W,
  localparam int unsigned IW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          srdyi,
  input  logic [W-1:0]  res_0,  res_1,  res_2,  res_3,  res_4,  res_5,  res_6,  res_7,
  input  logic [W-1:0]  res_8,  res_9,  res_10, res_11, res_12, res_13, res_14, res_15,
  input  logic [W-1:0]  res_16, res_17, res_18, res_19, res_20, res_21, res_22, res_23,
  input  logic [W-1:0]  res_24, res_25, res_26, res_27, res_28, res_29, res_30, res_31,
  input  logic          drdyi,
  input  logic          ovf_clr,
  output logic          srdyo,
  output logic [W-1:0]  dout,
  output logic [IW-1:0] ch,
  output logic          last,
  output logic          ovf,
  output logic [7:0]    drop_cnt
);

  logic [W-1:0]  w_res [NCH];
  drain_state_t  r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [1:0]    r_full, w_full_nxt;
  logic          r_wr_bank, r_rd_bank;
  logic          r_ovf;
  logic [7:0]    r_drop_cnt;
  logic          w_xfer, w_release, w_capture, w_drop;
  logic          w_valid;
  logic [W-1:0]  w_word0, w_word1;

  assign w_res = '{res_0,  res_1,  res_2,  res_3,  res_4,  res_5,  res_6,  res_7,
                   res_8,  res_9,  res_10, res_11, res_12, res_13, res_14, res_15,
                   res_16, res_17, res_18, res_19, res_20, res_21, res_22, res_23,
                   res_24, res_25, res_26, res_27, res_28, res_29, res_30, res_31};

  // A release of the write bank in the same cycle frees it for the new frame.
  assign w_valid   = (r_state == STREAM);
  assign w_xfer    = w_valid && drdyi;
  assign w_release = w_xfer && (r_idx == IW'(NCH-1));
  assign w_capture = srdyi && (!r_full[r_wr_bank] || (w_release && (r_wr_bank == r_rd_bank)));
  assign w_drop    = srdyi && !w_capture;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt = STREAM;
          w_idx_nxt   = '0;
        end
      end
      STREAM: begin
        if (w_release) begin
          w_idx_nxt = '0;
          if (!r_full[~r_rd_bank]) w_state_nxt = IDLE;
        end else if (w_xfer) begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
    endcase
  end

  // Clear before set so a same-bank release+capture leaves the bank full.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_capture) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_full    <= w_full_nxt;
      r_wr_bank <= r_wr_bank ^ w_capture;
      r_rd_bank <= r_rd_bank ^ w_release;
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (ovf_clr)                  r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  result_bank #(.NCH(NCH), .W(W)) u_bank0 (
    .clk    (clk),
    .i_load (w_capture && !r_wr_bank),
    .i_data (w_res),
    .i_idx  (r_idx),
    .o_word (w_word0)
  );

  result_bank #(.NCH(NCH), .W(W)) u_bank1 (
    .clk    (clk),
    .i_load (w_capture && r_wr_bank),
    .i_data (w_res),
    .i_idx  (r_idx),
    .o_word (w_word1)
  );

  assign srdyo    = w_valid;
  assign dout     = w_valid ? (r_rd_bank ? w_word1 : w_word0) : '0;
  assign ch       = r_idx;
  assign last     = w_valid && (r_idx == IW'(NCH-1));
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: directed frames, monitor-side word checking.
module tb_result_drain;
  import result_pkg::*;

  typedef struct packed {
    res_word_t  dout;
    logic [4:0] ch;
    logic       last;
  } exp_t;

  logic            clk, reset, srdyi, drdyi, ovf_clr;
  logic [RES_W-1:0] res [RES_NCH];
  logic            srdyo, last, ovf;
  logic [RES_W-1:0] dout;
  logic [4:0]      ch;
  logic [7:0]      drop_cnt;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   run = 0;
  int   last_run = 0;

  result_drain dut (
    .clk(clk), .reset(reset), .srdyi(srdyi),
    .res_0(res[0]),   .res_1(res[1]),   .res_2(res[2]),   .res_3(res[3]),
    .res_4(res[4]),   .res_5(res[5]),   .res_6(res[6]),   .res_7(res[7]),
    .res_8(res[8]),   .res_9(res[9]),   .res_10(res[10]), .res_11(res[11]),
    .res_12(res[12]), .res_13(res[13]), .res_14(res[14]), .res_15(res[15]),
    .res_16(res[16]), .res_17(res[17]), .res_18(res[18]), .res_19(res[19]),
    .res_20(res[20]), .res_21(res[21]), .res_22(res[22]), .res_23(res[23]),
    .res_24(res[24]), .res_25(res[25]), .res_26(res[26]), .res_27(res[27]),
    .res_28(res[28]), .res_29(res[29]), .res_30(res[30]), .res_31(res[31]),
    .drdyi(drdyi), .ovf_clr(ovf_clr),
    .srdyo(srdyo), .dout(dout), .ch(ch), .last(last), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Drive one frame for a single cycle; queue its words only if it should be kept.
  task automatic send_frame(input int base, input bit keep);
    exp_t e;
    for (int i = 0; i < RES_NCH; i++) res[i] = RES_W'(base + i);
    srdyi = 1'b1;
    if (keep) begin
      for (int i = 0; i < RES_NCH; i++) begin
        e.dout = RES_W'(base + i);
        e.ch   = 5'(i);
        e.last = (i == RES_NCH - 1);
        q.push_back(e);
      end
    end
    tick;
    srdyi = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int c;
    c = 0;
    while ((q.size() != 0 || srdyo) && c < 500) begin
      tick;
      c++;
    end
    chk({nm, "_queue_left"}, q.size(), 0);
  endtask

  // Monitor: compare every presented word with the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (srdyo) begin
        run++;
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_word: got ch=%0d dout=%0d, required no word", ch, dout);
        end else begin
          if (dout !== q[0].dout || ch !== q[0].ch || last !== q[0].last) begin
            n_errors++;
            $display("FAIL word: got dout=%0d ch=%0d last=%0b, required dout=%0d ch=%0d last=%0b",
                     dout, ch, last, q[0].dout, q[0].ch, q[0].last);
          end
          if (drdyi) void'(q.pop_front());
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        n_checks++;
        if (dout !== '0 || last !== 1'b0) begin
          n_errors++;
          $display("FAIL idle_outputs: got dout=%0d last=%0b, required 0 0", dout, last);
        end
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    int c;
    reset = 1'b1; srdyi = 1'b0; drdyi = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < RES_NCH; i++) res[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_srdyo", srdyo, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ch", ch, 0);
    chk("rst_last", last, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    tick;

    // Single frame, latency and exact run length.
    drdyi = 1'b1;
    send_frame(100, 1'b1);
    chk("lat_not_yet", srdyo, 0);
    tick;
    chk("lat_srdyo", srdyo, 1);
    chk("lat_ch0", ch, 0);
    chk("lat_dout0", dout, 100);
    wait_drain("single");
    tick;
    chk("single_run", last_run, 32);

    // Backpressure pattern 1,0,0 repeating.
    send_frame(200, 1'b1);
    c = 0;
    while ((q.size() != 0 || srdyo) && c < 500) begin
      drdyi = (c % 3 == 0);
      tick;
      c++;
    end
    chk("bp_queue_left", q.size(), 0);
    drdyi = 1'b1;
    tick;

    // Two frames one cycle apart stream without a bubble.
    send_frame(300, 1'b1);
    tick;
    send_frame(400, 1'b1);
    wait_drain("pair");
    tick;
    chk("pair_run", last_run, 64);

    // Third frame with both banks full is dropped; drop beats a clear.
    drdyi = 1'b0;
    send_frame(500, 1'b1);
    tick;
    send_frame(600, 1'b1);
    tick;
    send_frame(700, 1'b0);
    chk("drop_ovf", ovf, 1);
    chk("drop_cnt1", drop_cnt, 1);
    ovf_clr = 1'b1;
    send_frame(800, 1'b0);
    ovf_clr = 1'b0;
    chk("drop_clr_ovf", ovf, 1);
    chk("drop_clr_cnt", drop_cnt, 1);
    tick;
    chk("sticky_ovf", ovf, 1);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_cnt", drop_cnt, 0);
    drdyi = 1'b1;
    wait_drain("drop");

    // New frame on the final handshake of a full bank pair is accepted.
    drdyi = 1'b0;
    send_frame(1000, 1'b1);
    tick;
    send_frame(2000, 1'b1);
    tick;
    drdyi = 1'b1;
    c = 0;
    while (!(srdyo && ch == 5'd31) && c < 100) begin
      tick;
      c++;
    end
    chk("edge_reach_ch31", ch, 31);
    send_frame(3000, 1'b1);
    chk("edge_no_ovf", ovf, 0);
    chk("edge_no_drop", drop_cnt, 0);
    wait_drain("edge");

    // Reset in the middle of a frame.
    send_frame(4000, 1'b1);
    c = 0;
    while (!(srdyo && ch == 5'd10) && c < 100) begin
      tick;
      c++;
    end
    chk("mid_reach_ch10", ch, 10);
    reset = 1'b1;
    #1;
    chk("mid_rst_srdyo", srdyo, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_ch", ch, 0);
    chk("mid_rst_last", last, 0);
    q.delete();
    tick;
    tick;
    reset = 1'b0;
    repeat (4) tick;
    chk("post_rst_idle", srdyo, 0);
    send_frame(5000, 1'b1);
    tick;
    chk("post_rst_ch0", ch, 0);
    chk("post_rst_dout0", dout, 5000);
    wait_drain("post_rst");
    repeat (2) tick;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
